// File: rtl/bitty_uart_tx.sv
// bitty_uart_tx: sends one 16-bit word as two UART frames, low byte first and each byte LSB first.
// Default framing is 8N1. Defining BITTY_UART_TX_PARITY_EN inserts an even-parity bit after each byte.
module bitty_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy
);

    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef BITTY_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [7:0]    hi_q;
    logic [2:0]    bit_cnt_q;
    logic [BW-1:0] baud_q;
    logic          byte_idx_q;
    logic          tx_q;
    logic          ready_q;
    logic          busy_q;
`ifdef BITTY_UART_TX_PARITY_EN
    logic          par_q;
`endif

    logic baud_end;
    assign baud_end = (baud_q == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            hi_q       <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            byte_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef BITTY_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // The start bit is driven from the accept edge so tx falls one cycle after the handshake.
                    if (tx_valid && ready_q) begin
                        shreg_q    <= tx_data[7:0];
                        hi_q       <= tx_data[WORD_W-1:8];
                        byte_idx_q <= 1'b0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef BITTY_UART_TX_PARITY_EN
                        par_q      <= ^tx_data[7:0];
`endif
                        state_q    <= START;
                    end
                end
                default: begin
                    if (!baud_end) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        case (state_q)
                            START: begin
                                bit_cnt_q <= '0;
                                tx_q      <= shreg_q[0];
                                state_q   <= DATA;
                            end
                            DATA: begin
                                if (bit_cnt_q == 3'd7) begin
`ifdef BITTY_UART_TX_PARITY_EN
                                    tx_q    <= par_q;
                                    state_q <= PARITY;
`else
                                    tx_q    <= 1'b1;
                                    state_q <= STOP;
`endif
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                    shreg_q   <= {1'b0, shreg_q[7:1]};
                                    tx_q      <= shreg_q[1];
                                end
                            end
`ifdef BITTY_UART_TX_PARITY_EN
                            PARITY: begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
`endif
                            STOP: begin
                                // High byte chains straight into its start bit; no idle gap.
                                if (!byte_idx_q) begin
                                    byte_idx_q <= 1'b1;
                                    shreg_q    <= hi_q;
`ifdef BITTY_UART_TX_PARITY_EN
                                    par_q      <= ^hi_q;
`endif
                                    tx_q       <= 1'b0;
                                    state_q    <= START;
                                end else begin
                                    byte_idx_q <= 1'b0;
                                    tx_q       <= 1'b1;
                                    ready_q    <= 1'b1;
                                    busy_q     <= 1'b0;
                                    state_q    <= IDLE;
                                end
                            end
                            default: begin
                                tx_q    <= 1'b1;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule
